// File: rtl/acl2_sample_ctrl.sv
// acl2_sample_ctrl: powers up the ADXL362 then periodically burst-reads X/Y/Z through the SPI byte engine
module acl2_sample_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 500000,
  parameter int unsigned SAMPLE_PERIOD  = 1000000,
  parameter logic [7:0]  POWER_CTL_VAL  = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  spi_send_data,
  output logic        spi_begin,
  input  logic        spi_end,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_cs_n,
  output logic [11:0] accel_x,
  output logic [11:0] accel_y,
  output logic [11:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        overrun
);
  typedef enum logic [2:0] {STARTUP, WR, WAIT_CS, IDLE, RD} state_t;
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] send_n;
  logic [31:0] tmr, tmr_n;
  logic begin_n, pend, pend_n, tick, take, last, done_n, valid_n, cap;
  logic [7:0] xl, yl, zl;
  logic [3:0] xh, yh, zh;
  function automatic logic [7:0] byte_at(input logic rd, input logic [2:0] i);
    byte_at = rd ? (i == 3'd0 ? 8'h0B : i == 3'd1 ? 8'h0E : 8'h00)
                 : (i == 3'd0 ? 8'h0A : i == 3'd1 ? 8'h2D : POWER_CTL_VAL);
  endfunction
  assign cap = state == RD && spi_end;
  // next state, next registered outputs, shared startup/sample timer and pending flag
  always_comb begin
    state_n = state;
    idx_n   = idx;
    send_n  = spi_send_data;
    begin_n = spi_begin;
    take    = 1'b0;
    done_n  = init_done;
    valid_n = 1'b0;
    last    = idx == (state == RD ? 3'd7 : 3'd2);
    tick    = init_done && tmr == SAMPLE_PERIOD - 1;
    tmr_n   = init_done ? (tick ? 32'd0 : tmr + 32'd1) : (state == STARTUP ? tmr + 32'd1 : 32'd0);
    case (state)
      STARTUP: if (tmr >= STARTUP_CYCLES - 1 && spi_cs_n) begin
        state_n = WR;
        idx_n   = 3'd0;
        send_n  = byte_at(1'b0, 3'd0);
        begin_n = 1'b1;
      end
      WR, RD: if (spi_end) begin
        idx_n   = idx + 3'd1;
        send_n  = last ? spi_send_data : byte_at(state == RD, idx + 3'd1);
        begin_n = !last;
        state_n = last ? WAIT_CS : state;
      end
      WAIT_CS: if (spi_cs_n) begin
        state_n = IDLE;
        done_n  = 1'b1;
        valid_n = init_done;
      end
      IDLE: if (pend && spi_cs_n) begin
        state_n = RD;
        idx_n   = 3'd0;
        send_n  = byte_at(1'b1, 3'd0);
        begin_n = 1'b1;
        take    = 1'b1;
      end
      default: state_n = STARTUP;
    endcase
    pend_n = tick || (pend && !take);
  end
  // state register and registered SPI/status outputs
  always_ff @(posedge clk)
    if (rst) begin
      state         <= STARTUP;
      idx           <= 3'd0;
      tmr           <= 32'd0;
      pend          <= 1'b0;
      spi_send_data <= 8'h00;
      spi_begin     <= 1'b0;
      init_done     <= 1'b0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      tmr           <= tmr_n;
      pend          <= pend_n;
      spi_send_data <= send_n;
      spi_begin     <= begin_n;
      init_done     <= done_n;
      sample_valid  <= valid_n;
      overrun       <= overrun | (tick & pend & !take);
    end
  // shadow capture of read bytes 2..7 and simultaneous publish of all three axes
  always_ff @(posedge clk)
    if (rst) begin
      xl      <= 8'h00;
      yl      <= 8'h00;
      zl      <= 8'h00;
      xh      <= 4'h0;
      yh      <= 4'h0;
      zh      <= 4'h0;
      accel_x <= 12'h000;
      accel_y <= 12'h000;
      accel_z <= 12'h000;
    end else begin
      xl      <= cap && idx == 3'd2 ? spi_rx_data : xl;
      xh      <= cap && idx == 3'd3 ? spi_rx_data[3:0] : xh;
      yl      <= cap && idx == 3'd4 ? spi_rx_data : yl;
      yh      <= cap && idx == 3'd5 ? spi_rx_data[3:0] : yh;
      zl      <= cap && idx == 3'd6 ? spi_rx_data : zl;
      zh      <= cap && idx == 3'd7 ? spi_rx_data[3:0] : zh;
      accel_x <= valid_n ? {xh, xl} : accel_x;
      accel_y <= valid_n ? {yh, yl} : accel_y;
      accel_z <= valid_n ? {zh, zl} : accel_z;
    end
endmodule

// File: tb/tb_acl2_sample_ctrl.sv
// tb_acl2_sample_ctrl: byte-engine + ADXL362 model around acl2_sample_ctrl with a sample scoreboard
module tb_acl2_sample_ctrl;
  localparam int SP = 4000;
  localparam int SU = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] spi_send_data, spi_rx_data;
  logic spi_begin, spi_end, spi_cs_n;
  logic [11:0] accel_x, accel_y, accel_z;
  logic sample_valid, init_done, overrun;
  int checks = 0, failures = 0;
  acl2_sample_ctrl #(.STARTUP_CYCLES(SU), .SAMPLE_PERIOD(SP), .POWER_CTL_VAL(8'h02)) dut (
    .clk(clk), .rst(rst), .spi_send_data(spi_send_data), .spi_begin(spi_begin),
    .spi_end(spi_end), .spi_rx_data(spi_rx_data), .spi_cs_n(spi_cs_n),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .overrun(overrun));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input logic rd, input int i);
    exp_byte = rd ? (i == 0 ? 8'h0B : i == 1 ? 8'h0E : 8'h00) : (i == 0 ? 8'h0A : i == 1 ? 8'h2D : 8'h02);
  endfunction
  // MISO payloads (XL XH YL YH ZL ZH) and the hand-derived samples they must publish as
  logic [7:0] rxt [4][6] = '{'{8'h23, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hF8},
                             '{8'h00, 8'h07, 8'h01, 8'h00, 8'hFF, 8'hF7},
                             '{8'h80, 8'hF8, 8'h34, 8'h52, 8'h00, 8'h00},
                             '{8'h55, 8'hAA, 8'hAA, 8'h05, 8'h0F, 8'h3C}};
  logic [35:0] expt [4] = '{36'h123FFF800, 36'h7000017FF, 36'h880234000, 36'hA555AAC0F};
  logic [35:0] sb [$];
  typedef enum {E_IDLE, E_HOLD, E_XFER, E_GAP, E_CHK} e_t;
  e_t es = E_IDLE;
  int bcnt = 0, xcnt = 0, wlen = 0, rd_no = 0, byte_len = 4;
  logic [7:0] tx = 8'h00;
  logic [63:0] win = 64'h0;
  logic is_rd = 1'b0, exp_init = 1'b1;
  function automatic logic [7:0] miso(input logic rd, input int k, input int r);
    miso = !rd ? 8'h00 : k == 0 ? 8'hA5 : k == 1 ? 8'h5A : rxt[r % 4][k - 2];
  endfunction
  // SPI byte engine + sensor model: hold-state sample one cycle after each spi_end
  always @(posedge clk)
    if (rst) begin
      es <= E_IDLE; spi_cs_n <= 1'b1; spi_end <= 1'b0; spi_rx_data <= 8'h00;
      bcnt <= 0; wlen <= 0; win <= 64'h0; exp_init <= 1'b1;
    end else case (es)
      E_IDLE: if (spi_begin) begin
        spi_cs_n <= 1'b0; bcnt <= 0; wlen <= 0; win <= 64'h0; es <= E_HOLD;
      end
      E_HOLD: begin
        tx <= spi_send_data; is_rd <= spi_send_data == 8'h0B; xcnt <= 0; es <= E_XFER;
      end
      E_XFER: if (xcnt >= byte_len - 1) begin
        spi_end <= 1'b1; spi_rx_data <= miso(is_rd, bcnt, rd_no);
        win <= {win[55:0], tx}; wlen <= wlen + 1; bcnt <= bcnt + 1;
        if (is_rd && bcnt == 7) begin sb.push_back(expt[rd_no % 4]); rd_no <= rd_no + 1; end
        es <= E_GAP;
      end else xcnt <= xcnt + 1;
      E_GAP: begin spi_end <= 1'b0; es <= E_CHK; end
      default: if (spi_begin) begin
        tx <= spi_send_data; xcnt <= 0; es <= E_XFER;
      end else begin
        spi_cs_n <= 1'b1; es <= E_IDLE;
        chk("mosi_len", 64'(wlen), exp_init ? 64'd3 : 64'd8);
        chk("mosi_bytes", win, exp_init ? 64'h0000_0000_000A_2D02 : 64'h0B0E_0000_0000_0000);
        exp_init <= 1'b0;
      end
    endcase
  int cyc = 0, last_v = 0, n_valid = 0, end_pend = 0;
  logic chk_space = 1'b0, prev_valid = 1'b0;
  logic [35:0] e;
  // monitor: scoreboard pops on sample_valid, plus per-byte handshake timing
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (sample_valid) begin
        n_valid++;
        chk("valid_width", 64'(prev_valid), 64'd0);
        chk("sample_queued", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("accel_xyz", {28'h0, accel_x, accel_y, accel_z}, {28'h0, e});
        end
        if (chk_space && last_v > 0) chk("spacing", 64'(cyc - last_v), 64'(SP));
        last_v = cyc;
      end
      if (end_pend > 0) begin
        chk("send_after_end", 64'(spi_send_data),
            64'(exp_byte(is_rd, end_pend < (is_rd ? 8 : 3) ? end_pend : (is_rd ? 7 : 2))));
        chk("begin_after_end", 64'(spi_begin), 64'(end_pend < (is_rd ? 8 : 3)));
        end_pend = 0;
      end
      if (spi_end) begin
        chk("send_at_end", 64'(spi_send_data), 64'(exp_byte(is_rd, bcnt - 1)));
        chk("begin_at_end", 64'(spi_begin), 64'd1);
        end_pend = bcnt;
      end
    end else end_pend = 0;
    prev_valid = sample_valid;
  end
  task automatic startup_seq();
    int n;
    logic cs_low;
    n = 0;
    cs_low = 1'b0;
    while (!spi_begin && n < 100) begin
      @(negedge clk);
      n++;
      cs_low |= !spi_cs_n;
    end
    chk("startup_cycles", 64'(n), 64'(SU));
    chk("cs_idle_startup", 64'(cs_low), 64'd0);
    n = 0;
    while (!init_done && n < 200) begin @(negedge clk); n++; end
    chk("init_done", 64'(init_done), 64'd1);
    chk("cs_at_init", 64'(spi_cs_n), 64'd1);
  endtask
  task automatic wait_valid(input int cnt, input int bound, input string name);
    int base, n;
    base = n_valid;
    for (n = 0; n_valid < base + cnt && n < bound; n++) @(negedge clk);
    chk(name, 64'(n_valid - base), 64'(cnt));
  endtask
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_begin", 64'(spi_begin), 64'd0);
    chk("rst_send", 64'(spi_send_data), 64'd0);
    chk("rst_accel", {28'h0, accel_x, accel_y, accel_z}, 64'd0);
    chk("rst_flags", {61'h0, sample_valid, init_done, overrun}, 64'd0);
    rst = 1'b0;
    startup_seq();
    wait_valid(1, SP + 500, "first_sample");
    chk_space = 1'b1;
    wait_valid(5, 5 * SP + 500, "five_periods");
    chk_space = 1'b0;
    chk("no_overrun", 64'(overrun), 64'd0);
    byte_len = 1100;
    for (n = 0; !overrun && n < 14000; n++) @(negedge clk);
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_valid(1, 12000, "slow_sample");
    chk("overrun_sticky", 64'(overrun), 64'd1);
    byte_len = 4;
    for (n = 0; !(es == E_XFER && is_rd && bcnt == 3 && !spi_cs_n) && n < 12000; n++) @(negedge clk);
    chk("reach_byte4", 64'(es == E_XFER && is_rd && bcnt == 3), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_begin", 64'(spi_begin), 64'd0);
    chk("abort_valid", 64'(sample_valid), 64'd0);
    @(negedge clk);
    chk("abort_flags", {62'h0, init_done, overrun}, 64'd0);
    rst = 1'b0;
    startup_seq();
    wait_valid(1, SP + 500, "sample_after_reinit");
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
